// File: rtl/cpu_pkg.sv
// Shared CPU types and constants: FSM state encoding, datapath widths, memory timeout limit.
package cpu_pkg;
  localparam int unsigned XLEN               = 64;
  localparam int unsigned REGADDR_W          = 5;
  localparam int unsigned FLAGS_W            = 4;
  localparam int unsigned MEM_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2
  } mau_state_e;
endpackage

// File: rtl/memory_access_unit.sv
// Memory stage: holds one bundle, issues its data-memory access, emits a one-cycle writeback pulse.
// Optional MEM_ACCESS_TIMEOUT_EN aborts a stalled access after MEM_TIMEOUT_CYCLES ack-less cycles.
module memory_access_unit
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      alu_result,
  input  logic [XLEN-1:0]      operand_b,
  input  logic                 regwrite,
  input  logic                 memwrite,
  input  logic                 memtoreg,
  input  logic                 branch,
  input  logic                 setflags,
  input  logic [REGADDR_W-1:0] write_addr,
  input  logic [FLAGS_W-1:0]   flags,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [XLEN-1:0]      dmem_addr,
  output logic [XLEN-1:0]      dmem_wdata,
  input  logic                 dmem_ack,
  input  logic [XLEN-1:0]      dmem_rdata,
  output logic                 wb_valid,
  output logic [XLEN-1:0]      wb_data,
  output logic [REGADDR_W-1:0] wb_addr,
  output logic                 wb_regwrite,
  output logic                 wb_branch,
  output logic [FLAGS_W-1:0]   flags_q,
  output logic                 mem_error
);

  mau_state_e             state_q, state_d;
  logic [XLEN-1:0]        alu_q, alu_d, opb_q, opb_d, wb_data_q, wb_data_d;
  logic                   regwrite_q, regwrite_d, memwrite_q, memwrite_d;
  logic                   memtoreg_q, memtoreg_d, branch_q, branch_d;
  logic                   setflags_q, setflags_d;
  logic [REGADDR_W-1:0]   waddr_q, waddr_d;
  logic [FLAGS_W-1:0]     flags_in_q, flags_in_d, flags_d;
  logic                   err_q, err_d;
  logic                   accept;
`ifdef MEM_ACCESS_TIMEOUT_EN
  logic [7:0]             cnt_q, cnt_d;
`endif

  assign accept = in_valid & in_ready;

  always_comb begin
    state_d    = state_q;
    alu_d      = alu_q;
    opb_d      = opb_q;
    wb_data_d  = wb_data_q;
    regwrite_d = regwrite_q;
    memwrite_d = memwrite_q;
    memtoreg_d = memtoreg_q;
    branch_d   = branch_q;
    setflags_d = setflags_q;
    waddr_d    = waddr_q;
    flags_in_d = flags_in_q;
    flags_d    = flags_q;
    err_d      = err_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    // Flags commit uses the bundle leaving WB, even if a new one is accepted on the same edge.
    if (state_q == WB && setflags_q && !err_q) flags_d = flags_in_q;

    case (state_q)
      IDLE, WB: begin
        if (accept) begin
          alu_d      = alu_result;
          opb_d      = operand_b;
          wb_data_d  = alu_result;
          regwrite_d = regwrite;
          memwrite_d = memwrite;
          memtoreg_d = memtoreg;
          branch_d   = branch;
          setflags_d = setflags;
          waddr_d    = write_addr;
          flags_in_d = flags;
          err_d      = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
          cnt_d      = 8'd0;
`endif
          state_d    = (memwrite | memtoreg) ? REQ : WB;
        end else if (state_q == WB) begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (dmem_ack) begin
          state_d = WB;
          // A store with memtoreg also set keeps the ALU result.
          if (memtoreg_q && !memwrite_q) wb_data_d = dmem_rdata;
        end
`ifdef MEM_ACCESS_TIMEOUT_EN
        else if (cnt_q == 8'(MEM_TIMEOUT_CYCLES - 1)) begin
          state_d = WB;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      alu_q      <= '0;
      opb_q      <= '0;
      wb_data_q  <= '0;
      regwrite_q <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      branch_q   <= 1'b0;
      setflags_q <= 1'b0;
      waddr_q    <= '0;
      flags_in_q <= '0;
      flags_q    <= '0;
      err_q      <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      cnt_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      alu_q      <= alu_d;
      opb_q      <= opb_d;
      wb_data_q  <= wb_data_d;
      regwrite_q <= regwrite_d;
      memwrite_q <= memwrite_d;
      memtoreg_q <= memtoreg_d;
      branch_q   <= branch_d;
      setflags_q <= setflags_d;
      waddr_q    <= waddr_d;
      flags_in_q <= flags_in_d;
      flags_q    <= flags_d;
      err_q      <= err_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign in_ready    = (state_q != REQ);
  assign dmem_req    = (state_q == REQ);
  assign dmem_we     = dmem_req & memwrite_q;
  assign dmem_addr   = alu_q;
  assign dmem_wdata  = opb_q;
  assign wb_valid    = (state_q == WB);
  assign wb_data     = wb_data_q;
  assign wb_addr     = waddr_q;
  assign wb_branch   = branch_q;
  assign wb_regwrite = regwrite_q & ~err_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
  assign mem_error   = (state_q == WB) & err_q;
`else
  assign mem_error   = 1'b0 & err_q;
`endif

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit: ALU, load, store, flags, ack filtering, reset abort, optional timeout.
module tb_memory_access_unit;
  import cpu_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid, in_ready;
  logic [XLEN-1:0]      alu_result, operand_b;
  logic                 regwrite, memwrite, memtoreg, branch, setflags;
  logic [REGADDR_W-1:0] write_addr;
  logic [FLAGS_W-1:0]   flags;
  logic                 dmem_req, dmem_we, dmem_ack;
  logic [XLEN-1:0]      dmem_addr, dmem_wdata, dmem_rdata;
  logic                 wb_valid, wb_regwrite, wb_branch, mem_error;
  logic [XLEN-1:0]      wb_data;
  logic [REGADDR_W-1:0] wb_addr;
  logic [FLAGS_W-1:0]   flags_q;

  int total = 0;
  int bad   = 0;
  int req_cycles;

  memory_access_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .operand_b(operand_b),
    .regwrite(regwrite), .memwrite(memwrite), .memtoreg(memtoreg),
    .branch(branch), .setflags(setflags), .write_addr(write_addr), .flags(flags),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_addr(wb_addr),
    .wb_regwrite(wb_regwrite), .wb_branch(wb_branch),
    .flags_q(flags_q), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; alu_result = '0; operand_b = '0;
    regwrite = 0; memwrite = 0; memtoreg = 0; branch = 0; setflags = 0;
    write_addr = '0; flags = '0;
  endtask

  initial begin
    idle_inputs();
    dmem_ack = 0; dmem_rdata = '0;
    rst = 0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_flags_q", flags_q, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_mem_error", mem_error, 0);
    rst = 1;
    tick();

    // ALU op completes the cycle after accept
    in_valid = 1; alu_result = 64'h1234; regwrite = 1; write_addr = 5'd3; branch = 1;
    chk("alu_no_req_accept", dmem_req, 0);
    tick();
    idle_inputs();
    chk("alu_wb_valid", wb_valid, 1);
    chk("alu_wb_data", wb_data, 64'h1234);
    chk("alu_wb_addr", wb_addr, 3);
    chk("alu_wb_regwrite", wb_regwrite, 1);
    chk("alu_wb_branch", wb_branch, 1);
    chk("alu_no_req_wb", dmem_req, 0);
    tick();
    chk("alu_wb_pulse", wb_valid, 0);
    chk("alu_no_req_idle", dmem_req, 0);

    // Load with ack arriving in the third request cycle
    in_valid = 1; alu_result = 64'h100; memtoreg = 1; regwrite = 1; write_addr = 5'd9;
    tick();
    idle_inputs();
    req_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      if (dmem_req === 1'b1) req_cycles++;
      chk("ld_addr", dmem_addr, 64'h100);
      chk("ld_we", dmem_we, 0);
      chk("ld_in_ready", in_ready, 0);
      chk("ld_no_wb", wb_valid, 0);
      if (i == 2) begin dmem_ack = 1; dmem_rdata = 64'hDEAD; end
      tick();
    end
    dmem_ack = 0; dmem_rdata = '0;
    chk("ld_req_cycles", req_cycles, 3);
    chk("ld_wb_valid", wb_valid, 1);
    chk("ld_wb_data", wb_data, 64'hDEAD);
    chk("ld_wb_addr", wb_addr, 9);
    chk("ld_req_dropped", dmem_req, 0);
    tick();

    // Stray ack in IDLE is ignored
    dmem_ack = 1; dmem_rdata = 64'h5555;
    tick();
    dmem_ack = 0; dmem_rdata = '0;
    chk("stray_ack_no_wb", wb_valid, 0);
    chk("stray_ack_no_req", dmem_req, 0);

    // Store with memtoreg also set, acked in the first request cycle
    in_valid = 1; alu_result = 64'h200; operand_b = 64'hBEEF; memwrite = 1; memtoreg = 1;
    tick();
    idle_inputs();
    chk("st_req", dmem_req, 1);
    chk("st_we", dmem_we, 1);
    chk("st_wdata", dmem_wdata, 64'hBEEF);
    chk("st_addr", dmem_addr, 64'h200);
    dmem_ack = 1; dmem_rdata = 64'h1111;
    tick();
    dmem_ack = 0; dmem_rdata = '0;
    chk("st_wb_valid", wb_valid, 1);
    chk("st_wb_data", wb_data, 64'h200);
    tick();

    // Back-to-back ALU ops: only the first sets flags
    in_valid = 1; alu_result = 64'hA1; setflags = 1; flags = 4'b1010; write_addr = 5'd1;
    tick();
    chk("fl1_wb_valid", wb_valid, 1);
    chk("fl1_flags_before", flags_q, 4'b0000);
    chk("fl1_in_ready", in_ready, 1);
    alu_result = 64'hA2; setflags = 0; flags = 4'b0101; write_addr = 5'd2;
    tick();
    idle_inputs();
    chk("fl2_wb_valid", wb_valid, 1);
    chk("fl2_wb_data", wb_data, 64'hA2);
    chk("fl2_wb_addr", wb_addr, 2);
    chk("fl2_flags", flags_q, 4'b1010);
    tick();
    chk("fl_final_flags", flags_q, 4'b1010);
    chk("fl_final_idle", wb_valid, 0);

    // Reset mid-request abandons the access
    in_valid = 1; alu_result = 64'h300; memtoreg = 1; regwrite = 1;
    tick();
    idle_inputs();
    chk("rr_req_before", dmem_req, 1);
    #2 rst = 0;
    #1;
    chk("rr_req_dropped", dmem_req, 0);
    chk("rr_in_ready", in_ready, 1);
    chk("rr_flags", flags_q, 4'b0000);
    tick();
    chk("rr_no_wb", wb_valid, 0);
    #3 rst = 1;
    tick();
    chk("rr_still_idle", wb_valid, 0);
    in_valid = 1; alu_result = 64'h77; regwrite = 1; write_addr = 5'd7;
    tick();
    idle_inputs();
    chk("rr_alu_wb_valid", wb_valid, 1);
    chk("rr_alu_wb_data", wb_data, 64'h77);
    chk("rr_alu_wb_addr", wb_addr, 7);
    tick();

`ifdef MEM_ACCESS_TIMEOUT_EN
    // Unacknowledged load times out; flags stay at their current value
    in_valid = 1; alu_result = 64'h400; memtoreg = 1; regwrite = 1; setflags = 1; flags = 4'b1111;
    tick();
    idle_inputs();
    req_cycles = 0;
    for (int i = 0; i < 300; i++) begin
      if (wb_valid === 1'b1) break;
      if (dmem_req === 1'b1) req_cycles++;
      tick();
    end
    chk("to_wb_valid", wb_valid, 1);
    chk("to_req_cycles", req_cycles, MEM_TIMEOUT_CYCLES);
    chk("to_mem_error", mem_error, 1);
    chk("to_wb_regwrite", wb_regwrite, 0);
    tick();
    chk("to_flags", flags_q, 4'b0000);
    chk("to_idle_wb", wb_valid, 0);
    chk("to_idle_err", mem_error, 0);
    chk("to_idle_ready", in_ready, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_access_unit.md
MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on posedge clk.
REQ-002 rst  input  1  asynchronous, active-low reset; rst=0 clears state immediately, independent of clk.
REQ-003 in_valid  input  1  execution-stage bundle valid.
REQ-004 in_ready  output  1  unit can accept a bundle this cycle.
REQ-005 alu_result  input  64  ALU result; memory address for memory ops.
REQ-006 operand_b  input  64  store data.
REQ-007 regwrite, memwrite, memtoreg, branch, setflags  input  1 each  execution-stage control bits.
REQ-008 write_addr  input  5  destination register index.
REQ-009 flags  input  4  NZCV from ALU.
REQ-010 dmem_req  output  1  data-memory request.
REQ-011 dmem_we  output  1  1 = store, 0 = load.
REQ-012 dmem_addr, dmem_wdata  output  64 each  request address and store data.
REQ-013 dmem_ack  input  1  memory completion, one-cycle pulse.
REQ-014 dmem_rdata  input  64  load data, valid with dmem_ack.
REQ-015 wb_valid  output  1  writeback bundle valid, one-cycle pulse.
REQ-016 wb_data  output  64; wb_addr  output  5; wb_regwrite, wb_branch  output  1  writeback bundle.
REQ-017 flags_q  output  4  architectural NZCV register.
REQ-018 mem_error  output  1  access-timeout pulse.

Function
REQ-019 FSM states: IDLE, REQ, WB; encoding from shared package.
REQ-020 in_ready SHALL be 1 in IDLE and WB, 0 in REQ.
REQ-021 Accept (in_valid & in_ready) SHALL register all inputs; next state is REQ if memwrite|memtoreg, else WB.
REQ-022 In REQ, dmem_req=1 and dmem_addr/dmem_wdata/dmem_we (= registered memwrite) SHALL be held stable until the cycle dmem_ack=1.
REQ-023 On dmem_ack in REQ: next state WB; wb_data = dmem_rdata if the op is a load, else registered alu_result.
REQ-024 Non-memory op: wb_data = registered alu_result.
REQ-025 memwrite and memtoreg both set: SHALL be treated as a store; memtoreg is ignored.
REQ-026 In WB, wb_valid=1 for exactly one cycle; wb_addr, wb_regwrite, and wb_branch come from the registered bundle. There is no downstream backpressure.
REQ-027 WB with a new accept goes to REQ/WB per REQ-021, otherwise to IDLE; back-to-back ALU ops give one wb_valid per cycle.
REQ-028 Latency: ALU op accepted in cycle N gives wb_valid in N+1. Memory op: dmem_req from N+1; ack in cycle M gives wb_valid in M+1.
REQ-029 flags_q SHALL load registered flags in the WB cycle iff registered setflags=1.
REQ-030 dmem_ack outside REQ SHALL be ignored.
REQ-031 dmem_req, wb_valid, and mem_error outputs are 0 in IDLE.

Reset
REQ-032 rst=0: state IDLE; all outputs 0 (in_ready becomes 1 as IDLE); flags_q = 4'b0; all registered bundle fields 0.
REQ-033 Reset asserted during REQ SHALL drop dmem_req in the same cycle; the pending access is abandoned, with no writeback.

Configuration
REQ-034 Macro MEM_ACCESS_TIMEOUT_EN, defined: an 8-bit counter clears on REQ entry and increments each REQ cycle without ack. At MEM_TIMEOUT_CYCLES (package constant, 255), the access aborts: go to WB with wb_valid=1, wb_regwrite=0, mem_error=1 for that cycle, and flags_q unchanged.
REQ-035 Macro undefined: no counter; REQ waits indefinitely; mem_error tied 0.

Structure
REQ-036 Shared package cpu_pkg holds the FSM state enum, XLEN=64, REGADDR_W=5, FLAGS_W=4, and MEM_TIMEOUT_CYCLES.
REQ-037 No sub-module; the timeout counter stays inline under the macro.

Verification
REQ-038 ALU op: alu_result=64'h1234, regwrite=1, write_addr=3 -> next cycle wb_valid=1, wb_data=64'h1234, wb_addr=3, dmem_req never asserted.
REQ-039 Load: alu_result=64'h100, memtoreg=1; ack after 3 cycles with dmem_rdata=64'hDEAD -> dmem_req high 3 cycles with addr 64'h100, we=0; wb_data=64'hDEAD one cycle after ack; in_ready=0 throughout REQ.
REQ-040 Store: memwrite=1, operand_b=64'hBEEF, ack same cycle as first request -> dmem_we=1, wdata=64'hBEEF, wb_data=alu_result.
REQ-041 setflags=1, flags=4'b1010, then setflags=0, flags=4'b0101 -> flags_q=4'b1010 after both writebacks.
REQ-042 rst pulled low mid-REQ -> dmem_req=0 immediately, no wb_valid; after release, a new ALU op completes normally.
REQ-043 With MEM_ACCESS_TIMEOUT_EN defined, no ack for 255 cycles -> mem_error=1 and wb_valid=1 with wb_regwrite=0 in the same cycle, then IDLE.
